// File: rtl/regfile_pkg.sv
// Shared types and configuration limits for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int unsigned RF_MIN_DEPTH      = 2;
    localparam int unsigned RF_MIN_READ_PORTS = 1;
    localparam int unsigned RF_MAX_READ_PORTS = 4;
    localparam int unsigned RF_MAX_ADDR_WIDTH = 31;

    function automatic bit rf_cfg_ok(input int unsigned dw, input int unsigned aw,
                                     input int unsigned depth, input int unsigned rp,
                                     input int unsigned zr, input int unsigned bp);
        return (dw >= 1) && (aw >= 1) && (aw <= RF_MAX_ADDR_WIDTH) &&
               (depth >= RF_MIN_DEPTH) && (depth <= (32'd1 << aw)) &&
               (rp >= RF_MIN_READ_PORTS) && (rp <= RF_MAX_READ_PORTS) &&
               (zr <= 1) && (bp <= 1);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address decode, write-forwarding compare, output register.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P = 32,
    parameter int unsigned ADDR_WIDTH_P = 5,
    parameter int unsigned DEPTH_P      = 32,
    parameter int unsigned ZERO_REG_P   = 1,
    parameter int unsigned BYPASS_P     = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_rd_en,
    input  logic [ADDR_WIDTH_P-1:0] i_rd_addr,
    input  logic [DATA_WIDTH_P-1:0] i_mem [DEPTH_P],
    input  logic                    i_wr_fire,
    input  logic [ADDR_WIDTH_P-1:0] i_wr_addr,
    input  logic [DATA_WIDTH_P-1:0] i_wr_data,
    output logic [DATA_WIDTH_P-1:0] o_rd_data,
    output logic                    o_rd_valid
);

    localparam int unsigned IDX_W = $clog2(DEPTH_P);
    localparam logic [ADDR_WIDTH_P:0] DEPTH_W = (ADDR_WIDTH_P + 1)'(DEPTH_P);

    logic [DATA_WIDTH_P-1:0] rd_data_q, rd_data_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    addr_ok;
    logic                    fwd_hit;
    logic [DATA_WIDTH_P-1:0] entry;

    always_comb begin
        addr_ok    = ({1'b0, i_rd_addr} < DEPTH_W) && !((ZERO_REG_P != 0) && (i_rd_addr == '0));
        // i_wr_fire already excludes dropped writes, so forwarding never sees one
        fwd_hit    = (BYPASS_P != 0) && i_wr_fire && (i_wr_addr == i_rd_addr);
        entry      = '0;
        if (addr_ok) begin
            entry = fwd_hit ? i_wr_data : i_mem[i_rd_addr[IDX_W-1:0]];
        end
        rd_valid_d = i_rd_en;
        rd_data_d  = i_rd_en ? entry : rd_data_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with a one-write port, N registered read ports and a
// sequential clear sweep that runs after reset and on request.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P = 32,
    parameter int unsigned ADDR_WIDTH_P = 5,
    parameter int unsigned DEPTH_P      = 32,
    parameter int unsigned READ_PORTS_P = 2,
    parameter int unsigned ZERO_REG_P   = 1,
    parameter int unsigned BYPASS_P     = 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [READ_PORTS_P*ADDR_WIDTH_P-1:0] i_rd_addr,
    input  logic [READ_PORTS_P-1:0]              i_rd_en,
    input  logic [ADDR_WIDTH_P-1:0]              i_wr_addr,
    input  logic [DATA_WIDTH_P-1:0]              i_wr_data,
    input  logic                                 i_wr_enable,
    input  logic                                 i_clear,
    output logic [READ_PORTS_P*DATA_WIDTH_P-1:0] o_rd_data,
    output logic [READ_PORTS_P-1:0]              o_rd_valid,
    output logic                                 o_busy
);

    if (!rf_cfg_ok(DATA_WIDTH_P, ADDR_WIDTH_P, DEPTH_P, READ_PORTS_P, ZERO_REG_P, BYPASS_P)) begin : g_bad_cfg
        $error("regfile_mp: parameter out of range");
    end

    localparam int unsigned IDX_W = $clog2(DEPTH_P);
    localparam logic [ADDR_WIDTH_P:0]   DEPTH_W  = (ADDR_WIDTH_P + 1)'(DEPTH_P);
    localparam logic [ADDR_WIDTH_P-1:0] LAST_IDX = ADDR_WIDTH_P'(DEPTH_P - 1);

    rf_state_e               state_q, state_d;
    logic [ADDR_WIDTH_P-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH_P-1:0] mem_q [DEPTH_P];
    logic [DATA_WIDTH_P-1:0] mem_d [DEPTH_P];
    logic                    wr_addr_ok;
    logic                    wr_fire;
    logic [READ_PORTS_P-1:0] rd_go;

    always_comb begin
        wr_addr_ok = ({1'b0, i_wr_addr} < DEPTH_W) && !((ZERO_REG_P != 0) && (i_wr_addr == '0));
        wr_fire    = (state_q == READY) && i_wr_enable && wr_addr_ok;
        rd_go      = (state_q == READY) ? i_rd_en : '0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            CLEAR: begin
                if (i_clear) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                if (i_clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (state_q == CLEAR) begin
            mem_d[cnt_q[IDX_W-1:0]] = '0;
        end else if (wr_fire) begin
            mem_d[i_wr_addr[IDX_W-1:0]] = i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is not reset: the sweep that follows every reset zeroes it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    for (genvar k = 0; k < READ_PORTS_P; k++) begin : g_rd
        regfile_rd_port #(
            .DATA_WIDTH_P (DATA_WIDTH_P),
            .ADDR_WIDTH_P (ADDR_WIDTH_P),
            .DEPTH_P      (DEPTH_P),
            .ZERO_REG_P   (ZERO_REG_P),
            .BYPASS_P     (BYPASS_P)
        ) u_rd_port (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_rd_en    (rd_go[k]),
            .i_rd_addr  (i_rd_addr[k*ADDR_WIDTH_P +: ADDR_WIDTH_P]),
            .i_mem      (mem_q),
            .i_wr_fire  (wr_fire),
            .i_wr_addr  (i_wr_addr),
            .i_wr_data  (i_wr_data),
            .o_rd_data  (o_rd_data[k*DATA_WIDTH_P +: DATA_WIDTH_P]),
            .o_rd_valid (o_rd_valid[k])
        );
    end

    assign o_busy = (state_q == CLEAR);

endmodule
